// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared state, direction and lamp encodings for the intersection phase scheduler.
package intersection_phase_scheduler_pkg;

    localparam logic [2:0] ST_PARK = 3'd0;
    localparam logic [2:0] ST_NS_G = 3'd1;
    localparam logic [2:0] ST_NS_Y = 3'd2;
    localparam logic [2:0] ST_CLR  = 3'd3;
    localparam logic [2:0] ST_EW_G = 3'd4;
    localparam logic [2:0] ST_EW_Y = 3'd5;
    localparam logic [2:0] ST_WALK = 3'd6;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Head lamp vectors are ordered {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic logic [2:0] head_lamps(input logic [2:0] st, input logic dir);
        logic [2:0] lamps;
        lamps = LAMP_RED;
        if (dir == DIR_NS) begin
            if (st == ST_NS_G)      lamps = LAMP_GREEN;
            else if (st == ST_NS_Y) lamps = LAMP_YELLOW;
        end else begin
            if (st == ST_EW_G)      lamps = LAMP_GREEN;
            else if (st == ST_EW_Y) lamps = LAMP_YELLOW;
        end
        return lamps;
    endfunction

    function automatic logic [2:0] green_of(input logic dir);
        return (dir == DIR_NS) ? ST_NS_G : ST_EW_G;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Phase down-counter: loads duration-1 on a strobe, stops at zero, flags done at zero.
module intersection_phase_scheduler_phase_timer #(
    parameter int TW = 4,
    parameter logic [TW-1:0] RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic [TW-1:0] count,
    output logic          done
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= RESET_VALUE;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection sequencer: NS/EW greens with yellow and all-red clearance,
// demand-driven early green termination and a latched pedestrian walk phase.
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int GREEN_CYCLES     = 8,
    parameter int MIN_GREEN_CYCLES = 4,
    parameter int YELLOW_CYCLES    = 3,
    parameter int ALL_RED_CYCLES   = 2,
    parameter int WALK_CYCLES      = 6,
    parameter int TW               = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] GREEN_LOAD   = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] YELLOW_LOAD  = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] ALL_RED_LOAD = TW'(ALL_RED_CYCLES - 1);
    localparam logic [TW-1:0] WALK_LOAD    = TW'(WALK_CYCLES - 1);

    logic [2:0]    state, next_state;
    logic          next_dir, next_dir_d;
    logic [TW-1:0] timer_count, load_value;
    logic          timer_done, timer_load, min_met, walk_entry;

    // Timer counts down from GREEN-1, so elapsed green cycles = GREEN - timer.
    assign min_met    = (int'(timer_count) + MIN_GREEN_CYCLES) <= GREEN_CYCLES;
    assign walk_entry = (next_state == ST_WALK) && (state != ST_WALK);
    assign timer_load = (next_state != state) || ((state == ST_PARK) && !enable);

    intersection_phase_scheduler_phase_timer #(
        .TW          (TW),
        .RESET_VALUE (ALL_RED_LOAD)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (load_value),
        .count      (timer_count),
        .done       (timer_done)
    );

    always_comb begin
        next_state = state;
        next_dir_d = next_dir;
        case (state)
            ST_PARK: begin
                if (enable && timer_done)
                    next_state = green_of(next_dir);
            end
            ST_NS_G: begin
                if (timer_done || (min_met && (!enable || ((ew_req || ped_pending) && !ns_req)))) begin
                    next_state = ST_NS_Y;
                    next_dir_d = DIR_EW;
                end
            end
            ST_EW_G: begin
                if (timer_done || (min_met && (!enable || ((ns_req || ped_pending) && !ew_req)))) begin
                    next_state = ST_EW_Y;
                    next_dir_d = DIR_NS;
                end
            end
            ST_NS_Y, ST_EW_Y: begin
                if (timer_done)
                    next_state = ST_CLR;
            end
            ST_CLR: begin
                if (timer_done) begin
                    if (!enable)          next_state = ST_PARK;
                    else if (ped_pending) next_state = ST_WALK;
                    else                  next_state = green_of(next_dir);
                end
            end
            ST_WALK: begin
                if (timer_done)
                    next_state = enable ? green_of(next_dir) : ST_PARK;
            end
            default: next_state = ST_PARK;
        endcase
    end

    always_comb begin
        case (next_state)
            ST_NS_G, ST_EW_G: load_value = GREEN_LOAD;
            ST_NS_Y, ST_EW_Y: load_value = YELLOW_LOAD;
            ST_WALK:          load_value = WALK_LOAD;
            default:          load_value = ALL_RED_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                         <= ST_PARK;
            next_dir                      <= DIR_NS;
            ped_pending                   <= 1'b0;
            {ns_red, ns_yellow, ns_green} <= LAMP_RED;
            {ew_red, ew_yellow, ew_green} <= LAMP_RED;
            walk                          <= 1'b0;
        end else begin
            state                         <= next_state;
            next_dir                      <= next_dir_d;
            {ns_red, ns_yellow, ns_green} <= head_lamps(next_state, DIR_NS);
            {ew_red, ew_yellow, ew_green} <= head_lamps(next_state, DIR_EW);
            walk                          <= (next_state == ST_WALK);
            // Clearing on walk entry takes priority over a request in the same cycle.
            if (walk_entry)
                ped_pending <= 1'b0;
            else if (ped_req && (state != ST_WALK))
                ped_pending <= 1'b1;
        end
    end

    assign phase = state;

endmodule
